// File: rtl/s_rd_port_arbiter.sv
// -----------------------------------------------------------------------------
// s_rd_port_arbiter
//
// Read-port controller for the coefficient/sample memory S. It is shared by
// N_CH requesters. The current instruction selects either a fixed owner (EVP
// or EVB channel) or round-robin sharing. The block registers the S read
// address/enable, tracks reads in flight with a channel-id shift register and
// routes returned data back with a one-hot per-channel valid. A mode change
// drains outstanding reads; the RST opcode flushes them.
//
// Ports
//   clk        in   1               system clock, rising edge
//   rst        in   1               asynchronous active-high reset
//   instr      in   8               [1:0] opcode STP/EVP/EVB/RST, [7] shared
//   req        in   N_CH            per-channel read request (level)
//   addr_flat  in   N_CH*ADDR_W     channel i address at [i*ADDR_W +: ADDR_W]
//   gnt        out  N_CH            one-hot combinational grant
//   addr_err   out  N_CH            registered pulse: granted address >= S_SIZE
//   rd_addr_S  out  ADDR_W          registered S read address
//   rd_en_S    out  1               registered S read enable
//   rd_data_S  in   DATA_W          S read data, MEM_LAT cycles after rd_en_S
//   rdata_out  out  DATA_W          registered returned data (broadcast)
//   rvalid     out  N_CH            one-hot valid qualifying rdata_out
//   busy       out  1               reads in flight or draining
// -----------------------------------------------------------------------------
module s_rd_port_arbiter #(
  parameter int S_SIZE  = 88,
  parameter int N_CH    = 2,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int EVP_CH  = 0,
  parameter int EVB_CH  = 1,
  localparam int ADDR_W = (S_SIZE > 1) ? $clog2(S_SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               instr,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*ADDR_W-1:0]   addr_flat,
  output logic [N_CH-1:0]          gnt,
  output logic [N_CH-1:0]          addr_err,
  output logic [ADDR_W-1:0]        rd_addr_S,
  output logic                     rd_en_S,
  input  logic [DATA_W-1:0]        rd_data_S,
  output logic [DATA_W-1:0]        rdata_out,
  output logic [N_CH-1:0]          rvalid,
  output logic                     busy
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0]   EVP_ID     = CH_W'(EVP_CH);
  localparam logic [CH_W-1:0]   EVB_ID     = CH_W'(EVB_CH);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(S_SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_t;
  typedef enum logic [1:0] {MODE_STP, MODE_FIX_EVP, MODE_FIX_EVB, MODE_SHARED} mode_t;

  state_t             r_state, w_state_next;
  mode_t              r_cur_mode, w_mode;
  logic               w_is_rst;
  logic               w_load_mode;
  logic               w_grant_en;

  logic [CH_W-1:0]    r_rr_ptr;
  logic [CH_W-1:0]    w_rr_next;
  logic [CH_W-1:0]    w_sel_id;
  logic               w_gnt_any;
  logic [N_CH-1:0]    w_gnt;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic               w_addr_ok;
  logic               w_issue;

  logic               r_rd_en;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [CH_W-1:0]    r_rd_id;
  logic [N_CH-1:0]    r_addr_err;
  logic [DATA_W-1:0]  r_rdata;
  logic [N_CH-1:0]    r_rvalid;

  // Stage 0 of the tracking chain is the issue register itself; stages
  // 1..MEM_LAT are the in-flight reads, stage MEM_LAT lines up with rd_data_S.
  logic [MEM_LAT:0]   w_stg_vld;
  logic [CH_W-1:0]    w_stg_id [MEM_LAT+1];
  logic               w_inflight;
  logic [N_CH-1:0]    w_ret_onehot;

  // Instruction bits [6:2] carry nothing for this block.
  logic               w_unused_instr;
  assign w_unused_instr = ^instr[6:2];

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mode   = MODE_STP;
    w_is_rst = 1'b0;
    case (instr[1:0])
      2'b01:   w_mode = instr[7] ? MODE_SHARED : MODE_FIX_EVP;
      2'b10:   w_mode = instr[7] ? MODE_SHARED : MODE_FIX_EVB;
      2'b11:   w_is_rst = 1'b1;
      default: w_mode = MODE_STP;
    endcase
  end

  assign w_inflight = |w_stg_vld;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load_mode  = 1'b0;
    w_grant_en   = 1'b0;
    if (w_is_rst) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mode != MODE_STP) begin
            w_load_mode  = 1'b1;
            w_state_next = ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A mode change blocks grants this cycle; outstanding reads finish
          // in DRAIN before the new mode is loaded from IDLE.
          if (w_mode != r_cur_mode) begin
            w_state_next = w_inflight ? ST_DRAIN : ST_IDLE;
          end else begin
            w_grant_en = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!w_inflight) begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_any = 1'b0;
    w_sel_id  = '0;
    if (w_grant_en) begin
      if (r_cur_mode == MODE_SHARED) begin
        // First requester at or after rr_ptr, wrapping modulo N_CH.
        for (int k = 0; k < N_CH; k++) begin
          idx = int'(r_rr_ptr) + k;
          if (idx >= N_CH) begin
            idx = idx - N_CH;
          end
          if (!w_gnt_any && req[idx]) begin
            w_gnt_any = 1'b1;
            w_sel_id  = CH_W'(idx);
          end
        end
      end else if (r_cur_mode == MODE_FIX_EVP) begin
        w_sel_id  = EVP_ID;
        w_gnt_any = req[EVP_CH];
      end else if (r_cur_mode == MODE_FIX_EVB) begin
        w_sel_id  = EVB_ID;
        w_gnt_any = req[EVB_CH];
      end
    end
  end

  assign w_gnt      = w_gnt_any ? (N_CH'(1) << w_sel_id) : '0;
  assign w_sel_addr = addr_flat[int'(w_sel_id)*ADDR_W +: ADDR_W];
  assign w_addr_ok  = ({1'b0, w_sel_addr} < ADDR_LIMIT);
  assign w_issue    = w_gnt_any & w_addr_ok;
  assign w_rr_next  = (int'(w_sel_id) == N_CH-1) ? '0 : (w_sel_id + CH_W'(1));

  // ---------------------------------------------------------------------------
  // State, issue and return registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur_mode <= MODE_STP;
      r_rr_ptr   <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_id    <= '0;
      r_addr_err <= '0;
      r_rdata    <= '0;
      r_rvalid   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_mode) begin
        r_cur_mode <= w_mode;
      end
      // The pointer also advances past a channel whose address was illegal:
      // that request was consumed by the grant.
      if (w_gnt_any && (r_cur_mode == MODE_SHARED)) begin
        r_rr_ptr <= w_rr_next;
      end
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_rd_addr <= w_sel_addr;
        r_rd_id   <= w_sel_id;
      end
      r_addr_err <= (w_gnt_any && !w_addr_ok) ? w_gnt : '0;
      // A flush also suppresses the return whose data is on rd_data_S now.
      if (w_stg_vld[MEM_LAT] && !w_is_rst) begin
        r_rdata  <= rd_data_S;
        r_rvalid <= w_ret_onehot;
      end else begin
        r_rvalid <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight tracking chain
  // ---------------------------------------------------------------------------
  assign w_stg_vld[0] = r_rd_en;
  assign w_stg_id[0]  = r_rd_id;

  genvar gi;
  generate
    for (gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
      logic            r_vld;
      logic [CH_W-1:0] r_id;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= 1'b0;
          r_id  <= '0;
        end else begin
          r_vld <= w_stg_vld[gi] & ~w_is_rst;
          r_id  <= w_stg_id[gi];
        end
      end
      assign w_stg_vld[gi+1] = r_vld;
      assign w_stg_id[gi+1]  = r_id;
    end
  endgenerate

  assign w_ret_onehot = N_CH'(1) << w_stg_id[MEM_LAT];

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt       = w_gnt;
  assign addr_err  = r_addr_err;
  assign rd_addr_S = r_rd_addr;
  assign rd_en_S   = r_rd_en;
  assign rdata_out = r_rdata;
  assign rvalid    = r_rvalid;
  assign busy      = w_inflight | (r_state == ST_DRAIN);

endmodule
